// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage hazard detector, stall/flush controller and event counters
module hazard_stall_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [4:0]           IDrs,
  input  logic [4:0]           IDrt,
  input  logic                 IDUsesRt,
  input  logic                 IDIsBranch,
  input  logic                 BranchTaken,
  input  logic                 IDIsJump,
  input  logic                 EXMemRead,
  input  logic                 EXRegWrite,
  input  logic [4:0]           EXrd,
  input  logic                 MemMemRead,
  input  logic [4:0]           Memrd,
  input  logic                 MemBusy,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic                 IFIDFlush,
  output logic                 IDEXBubble,
  output logic                 PipeEn,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  // HOLD2 owes a second bubble to a branch whose operand is a load still in EX
  typedef enum logic {RUN, HOLD2} state_t;

  state_t state, state_n;

  logic ex_match, mem_match;
  logic lu, ba, ble, blm;
  logic hazard, redirect;

  // Source-operand matches against EX and MEM destinations; $0 is never a dependency
  always_comb begin
    ex_match  = (EXrd != 5'd0) &&
                ((EXrd == IDrs) || (IDUsesRt && (EXrd == IDrt)));
    mem_match = (Memrd != 5'd0) &&
                ((Memrd == IDrs) || (IDUsesRt && (Memrd == IDrt)));
    lu        = EXMemRead & ex_match;
    ba        = IDIsBranch & EXRegWrite & ~EXMemRead & ex_match;
    ble       = IDIsBranch & EXMemRead & ex_match;
    blm       = IDIsBranch & MemMemRead & mem_match;
    hazard    = lu | ba | ble | blm;
    redirect  = (IDIsBranch & BranchTaken) | IDIsJump;
  end

  // Control outputs and next state; Reset, then MemBusy, then stall, then flush
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    PipeEn     = 1'b1;
    state_n    = state;
    if (Reset) begin
      state_n = RUN;
    end else if (MemBusy) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      PipeEn    = 1'b0;
    end else if (state == HOLD2) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      state_n    = RUN;
    end else if (hazard) begin
      // The branch outcome is untrusted while operands are pending, so no flush here
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      state_n    = ble ? HOLD2 : RUN;
    end else if (redirect) begin
      IFIDFlush = 1'b1;
    end
  end

  // State register; a busy memory freezes it through state_n
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Wrap-around performance counters, frozen while memory is busy
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (!MemBusy) begin
      if (IDEXBubble) StallCount <= StallCount + CNT_WIDTH'(1);
      if (IFIDFlush)  FlushCount <= FlushCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed and randomized checks of hazard_stall_unit against a reference model
module tb_hazard_stall_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  IDrs, IDrt, EXrd, Memrd;
  logic        IDUsesRt, IDIsBranch, BranchTaken, IDIsJump;
  logic        EXMemRead, EXRegWrite, MemMemRead, MemBusy;
  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeEn;
  logic [15:0] StallCount, FlushCount;

  int tests  = 0;
  int failed = 0;

  // reference model state: bubbles still owed, event totals
  int m_owed  = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_stall_unit #(.CNT_WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .IDrs(IDrs), .IDrt(IDrt), .IDUsesRt(IDUsesRt),
    .IDIsBranch(IDIsBranch), .BranchTaken(BranchTaken), .IDIsJump(IDIsJump),
    .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite), .EXrd(EXrd),
    .MemMemRead(MemMemRead), .Memrd(Memrd), .MemBusy(MemBusy),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .PipeEn(PipeEn),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit depends_on(input logic [4:0] r);
    return (r != 0) && (r == IDrs || (IDUsesRt && r == IDrt));
  endfunction

  function automatic bit needs_two_bubbles();
    return IDIsBranch && EXMemRead && depends_on(EXrd);
  endfunction

  // expected {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeEn}
  function automatic logic [4:0] ref_out();
    bit must_wait;
    if (Reset)   return 5'b11001;
    if (MemBusy) return 5'b00000;
    if (m_owed > 0) return 5'b00011;
    must_wait = (EXMemRead && depends_on(EXrd)) ||
                (IDIsBranch && EXRegWrite && depends_on(EXrd)) ||
                (IDIsBranch && MemMemRead && depends_on(Memrd));
    if (must_wait) return 5'b00011;
    if ((IDIsBranch && BranchTaken) || IDIsJump) return 5'b11101;
    return 5'b11001;
  endfunction

  task automatic model_reset();
    m_owed = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic clear_inputs();
    IDrs = 0; IDrt = 0; EXrd = 0; Memrd = 0;
    IDUsesRt = 0; IDIsBranch = 0; BranchTaken = 0; IDIsJump = 0;
    EXMemRead = 0; EXRegWrite = 0; MemMemRead = 0; MemBusy = 0;
  endtask

  // check mid-cycle, then advance the model across the rising edge
  task automatic cycle(input string tag);
    logic [4:0] e;
    bit two;
    @(negedge Clk);
    e   = ref_out();
    two = needs_two_bubbles();
    chk({tag, "_ctl"}, 32'({PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeEn}), 32'(e));
    chk({tag, "_stall_cnt"}, 32'(StallCount), 32'(m_stall & 16'hFFFF));
    chk({tag, "_flush_cnt"}, 32'(FlushCount), 32'(m_flush & 16'hFFFF));
    @(posedge Clk);
    if (!Reset && !MemBusy) begin
      if (e[1]) m_stall++;
      if (e[2]) m_flush++;
      if (m_owed > 0) m_owed--;
      else if (two) m_owed = 1;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    Reset = 1;
    #1;
    chk("reset_ctl", 32'({PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeEn}), 32'(5'b11001));
    chk("reset_stall_cnt", 32'(StallCount), 32'd0);
    chk("reset_flush_cnt", 32'(FlushCount), 32'd0);
    @(posedge Clk); #1;
    Reset = 0;
    model_reset();

    // load-use on rs
    EXMemRead = 1; EXrd = 5; IDrs = 5;
    cycle("lu");
    clear_inputs();
    cycle("lu_after");

    // $0 never matches; rt ignored when unused
    EXMemRead = 1; EXrd = 0; IDrs = 0;
    cycle("zero_reg");
    EXrd = 7; IDrt = 7; IDUsesRt = 0; IDrs = 1;
    cycle("rt_unused");
    IDUsesRt = 1;
    cycle("rt_used");
    clear_inputs();

    // branch after load: two bubbles, BranchTaken ignored meanwhile
    IDIsBranch = 1; BranchTaken = 1; EXMemRead = 1; EXrd = 3; IDrs = 3;
    cycle("ble_1");
    EXMemRead = 0; EXrd = 0;
    cycle("ble_2");
    cycle("ble_resolve");
    clear_inputs();
    cycle("ble_idle");

    // taken branch and jump flushes
    IDIsBranch = 1; BranchTaken = 1;
    cycle("br_taken");
    clear_inputs(); IDIsJump = 1;
    cycle("jump");
    clear_inputs(); IDIsBranch = 1; BranchTaken = 0;
    cycle("br_not_taken");
    clear_inputs();

    // branch needs ALU result in EX, and load in MEM
    IDIsBranch = 1; EXRegWrite = 1; EXrd = 9; IDrt = 9; IDUsesRt = 1;
    cycle("ba");
    clear_inputs(); IDIsBranch = 1; MemMemRead = 1; Memrd = 4; IDrs = 4;
    cycle("blm");
    clear_inputs();

    // memory busy while in HOLD2
    IDIsBranch = 1; EXMemRead = 1; EXrd = 6; IDrs = 6;
    cycle("busy_enter");
    clear_inputs(); MemBusy = 1;
    for (int i = 0; i < 3; i++) cycle("busy_hold");
    MemBusy = 0;
    cycle("busy_release");
    cycle("busy_run");

    // asynchronous reset while in HOLD2
    IDIsBranch = 1; EXMemRead = 1; EXrd = 2; IDrs = 2;
    cycle("arst_enter");
    #2 Reset = 1;
    #1;
    chk("arst_stall_cnt", 32'(StallCount), 32'd0);
    chk("arst_flush_cnt", 32'(FlushCount), 32'd0);
    chk("arst_ctl", 32'({PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeEn}), 32'(5'b11001));
    model_reset();
    #1 Reset = 0;
    clear_inputs();
    cycle("arst_run");

    // randomized traffic over a small register range to provoke collisions
    for (int i = 0; i < 400; i++) begin
      IDrs        = 5'($urandom_range(0, 3));
      IDrt        = 5'($urandom_range(0, 3));
      EXrd        = 5'($urandom_range(0, 3));
      Memrd       = 5'($urandom_range(0, 3));
      IDUsesRt    = 1'($urandom);
      IDIsBranch  = 1'($urandom);
      BranchTaken = 1'($urandom);
      IDIsJump    = ($urandom_range(0, 5) == 0);
      EXMemRead   = 1'($urandom);
      EXRegWrite  = 1'($urandom);
      MemMemRead  = 1'($urandom);
      MemBusy     = ($urandom_range(0, 4) == 0);
      cycle("rand");
    end
    clear_inputs();
    cycle("rand_drain");

    // stall counter wraps past 0xFFFF
    Reset = 1; #1; Reset = 0;
    model_reset();
    EXMemRead = 1; EXrd = 5; IDrs = 5;
    for (int i = 0; i < 65535; i++) begin
      @(posedge Clk);
      m_stall++;
    end
    #1;
    cycle("wrap_top");
    cycle("wrap_zero");
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
ID-stage hazard detector and pipeline stall/flush controller for the 5-stage MIPS datapath. It is the counterpart of EX-stage forwarding. It detects dependencies that forwarding cannot resolve: load-use, and branch operands compared in ID. It then freezes PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on taken branches and jumps. It also freezes the whole pipeline while data memory is busy, and keeps stall and flush performance counters.

Parameters:
CNT_WIDTH, 16, width of StallCount and FlushCount (wrap-around counters)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
IDrs  input  5  rs field of instruction in ID
IDrt  input  5  rt field of instruction in ID
IDUsesRt  input  1  ID instruction reads rt as a source
IDIsBranch  input  1  ID instruction is beq/bne (compares in ID)
BranchTaken  input  1  ID branch comparison result (valid when IDIsBranch)
IDIsJump  input  1  ID instruction is j/jal/jr
EXMemRead  input  1  instruction in EX is a load
EXRegWrite  input  1  instruction in EX writes a register
EXrd  input  5  destination register of EX instruction (post RegDst mux)
MemMemRead  input  1  instruction in MEM is a load
Memrd  input  5  destination register of MEM instruction
MemBusy  input  1  data memory not ready; freeze entire pipeline
PCWrite  output  1  PC register enable
IFIDWrite  output  1  IF/ID register enable
IFIDFlush  output  1  clear IF/ID to nop on next edge
IDEXBubble  output  1  zero ID/EX control signals on next edge
PipeEn  output  1  enable for ID/EX, EX/MEM and MEM/WB registers
StallCount  output  CNT_WIDTH  cycles in which a bubble was injected
FlushCount  output  CNT_WIDTH  cycles in which IFIDFlush was asserted

Behaviour:
- Reset (async, any time): state=RUN, StallCount=0, FlushCount=0. Outputs while Reset is high: PCWrite=1, IFIDWrite=1, PipeEn=1, IFIDFlush=0, IDEXBubble=0. Reset mid-stall abandons the pending stall.
- Match terms (combinational). Register $0 never matches.
  - mRs = (X != 0) & (X == IDrs)
  - mRt = IDUsesRt & (X != 0) & (X == IDrt)
- Hazard terms (combinational):
  - LU = EXMemRead & match(EXrd): load-use.
  - BA = IDIsBranch & EXRegWrite & ~EXMemRead & match(EXrd): branch needs an EX ALU result.
  - BLE = IDIsBranch & EXMemRead & match(EXrd): branch needs a load in EX; requires 2 bubbles.
  - BLM = IDIsBranch & MemMemRead & match(Memrd): branch needs a load in MEM.
- States: RUN and HOLD2.
- RUN, MemBusy=0:
  - If LU|BA|BLM|BLE: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, PipeEn=1. Next state is HOLD2 if BLE, else RUN.
  - Otherwise, if (IDIsBranch & BranchTaken) | IDIsJump: IFIDFlush=1, PCWrite=1, IFIDWrite=1, IDEXBubble=0.
  - Otherwise all enables are 1 and flush/bubble are 0.
- HOLD2, MemBusy=0:
  - Unconditionally PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0. Next state RUN.
  - The branch is re-evaluated in RUN on the following cycle.
- MemBusy=1 (either state; overrides everything):
  - PCWrite=0, IFIDWrite=0, PipeEn=0, IDEXBubble=0, IFIDFlush=0.
  - State and counters hold.
- Priority: Reset > MemBusy > stall > flush. A flush never coincides with a stall, because the branch outcome is not trusted while its operands are pending.
- Counters update on the rising edge when MemBusy=0:
  - StallCount += 1 when IDEXBubble=1.
  - FlushCount += 1 when IFIDFlush=1.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- Latency: all control outputs are combinational, valid in the same cycle as their inputs. Counters reflect an event on the edge after it.

Test Plan:
- Load-use: EXMemRead=1, EXrd=5, IDrs=5 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1. State stays RUN. StallCount 0->1.
- $0 and rt-unused: EXMemRead=1, EXrd=0, IDrs=0 -> no stall. Separately EXrd=7, IDrt=7, IDUsesRt=0 -> no stall.
- Branch after load: IDIsBranch=1, EXMemRead=1, EXrd=3, IDrs=3 -> bubble this cycle, state HOLD2, bubble next cycle, then RUN. StallCount=2. BranchTaken is ignored during both cycles.
- Taken branch with no hazard: IDIsBranch=1, BranchTaken=1 -> IFIDFlush=1 for one cycle, PCWrite=1. FlushCount 0->1. Repeat the same case with IDIsJump=1 -> FlushCount=2.
- MemBusy freeze during HOLD2: assert MemBusy for 3 cycles -> all enables 0, state stays HOLD2, counters hold. Deassert -> one bubble, then RUN.
- Async reset in HOLD2, mid-cycle -> state RUN and counters 0 immediately, without waiting for a clock edge. Also drive StallCount to 0xFFFF with CNT_WIDTH=16 -> the next stall wraps it to 0.
